// File: rtl/lab2_proc_mem_arb_if.sv
// Memory message types and the request/response stream pair used on each
// arbiter port (processor-side fetch/data ports and the shared memory port).
package lab2_proc_mem_arb_pkg;

  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

endpackage

interface lab2_proc_mem_arb_if;
  import lab2_proc_mem_arb_pkg::*;

  // Handshake: a message moves on a rising clk edge where val && rdy are both
  // high; val never waits on rdy, and msg is meaningful only while val is high.
  mem_req_4B_t  reqstream_msg;
  logic         reqstream_val;
  logic         reqstream_rdy;
  mem_resp_4B_t respstream_msg;
  logic         respstream_val;
  logic         respstream_rdy;

  modport master (
    output reqstream_msg, reqstream_val,
    input  reqstream_rdy,
    input  respstream_msg, respstream_val,
    output respstream_rdy
  );

  modport slave (
    input  reqstream_msg, reqstream_val,
    output reqstream_rdy,
    output respstream_msg, respstream_val,
    input  respstream_rdy
  );

endinterface

// File: rtl/lab2_proc_mem_arb.sv
// Round-robin fetch/data arbiter onto one in-order memory port, with a tracking
// FIFO that routes responses back. LAB2_PROC_MEM_ARB_STATS_EN adds grant/stall counters.
module lab2_proc_mem_arb
  import lab2_proc_mem_arb_pkg::*;
#(
  parameter int p_max_outstanding = 4
) (
  input  logic clk,
  input  logic reset,
  lab2_proc_mem_arb_if.slave  imem,
  lab2_proc_mem_arb_if.slave  dmem,
  lab2_proc_mem_arb_if.master mem
`ifdef LAB2_PROC_MEM_ARB_STATS_EN
  ,
  output logic [31:0] num_imem_grants,
  output logic [31:0] num_dmem_grants,
  output logic [31:0] num_full_stalls
`endif
);

  localparam int PW = (p_max_outstanding > 1) ? $clog2(p_max_outstanding) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(p_max_outstanding);

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          rr_q, rr_d;
  logic          trk_id_q  [p_max_outstanding];
  logic [7:0]    trk_opq_q [p_max_outstanding];

  logic full, empty, any_val, gnt_imem, gnt_dmem;
  logic push, pop, head_id, sel_resp_rdy;
  logic [7:0] push_opq;

  always_comb begin
    full     = (count_q == MAX_CNT);
    empty    = (count_q == '0);
    any_val  = imem.reqstream_val || dmem.reqstream_val;
    // rr_q == 0 favours imem when both ask; a lone requester always wins.
    gnt_imem = imem.reqstream_val && (!dmem.reqstream_val || !rr_q);
    gnt_dmem = dmem.reqstream_val && !gnt_imem;

    // Outputs are forced low while reset is held; full already stalls on its own.
    mem.reqstream_val        = any_val && !full && reset;
    mem.reqstream_msg        = gnt_dmem ? dmem.reqstream_msg : imem.reqstream_msg;
    mem.reqstream_msg.opaque = gnt_dmem ? 8'h01 : 8'h00;
    imem.reqstream_rdy       = gnt_imem && mem.reqstream_rdy && !full && reset;
    dmem.reqstream_rdy       = gnt_dmem && mem.reqstream_rdy && !full && reset;
    push     = mem.reqstream_val && mem.reqstream_rdy;
    push_opq = gnt_dmem ? dmem.reqstream_msg.opaque : imem.reqstream_msg.opaque;

    head_id      = trk_id_q[rptr_q];
    sel_resp_rdy = head_id ? dmem.respstream_rdy : imem.respstream_rdy;
    mem.respstream_rdy        = sel_resp_rdy && !empty;
    imem.respstream_val       = mem.respstream_val && !empty && !head_id;
    dmem.respstream_val       = mem.respstream_val && !empty && head_id;
    imem.respstream_msg       = mem.respstream_msg;
    imem.respstream_msg.opaque = trk_opq_q[rptr_q];
    dmem.respstream_msg       = mem.respstream_msg;
    dmem.respstream_msg.opaque = trk_opq_q[rptr_q];
    pop = mem.respstream_val && mem.respstream_rdy;

    count_d = count_q + CW'(push) - CW'(pop);
    wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
    rr_d    = push ? gnt_imem : rr_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      rr_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      rr_q    <= rr_d;
    end
  end

  // Tracking payload needs no reset: count_q alone says which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      trk_id_q[wptr_q]  <= gnt_dmem;
      trk_opq_q[wptr_q] <= push_opq;
    end
  end

`ifdef LAB2_PROC_MEM_ARB_STATS_EN
  logic [31:0] imem_grants_q, imem_grants_d;
  logic [31:0] dmem_grants_q, dmem_grants_d;
  logic [31:0] full_stalls_q, full_stalls_d;

  always_comb begin
    imem_grants_d = imem_grants_q + 32'(push && gnt_imem);
    dmem_grants_d = dmem_grants_q + 32'(push && gnt_dmem);
    full_stalls_d = full_stalls_q + 32'(any_val && full);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_grants_q <= '0;
      dmem_grants_q <= '0;
      full_stalls_q <= '0;
    end else begin
      imem_grants_q <= imem_grants_d;
      dmem_grants_q <= dmem_grants_d;
      full_stalls_q <= full_stalls_d;
    end
  end

  assign num_imem_grants = imem_grants_q;
  assign num_dmem_grants = dmem_grants_q;
  assign num_full_stalls = full_stalls_q;
`endif

endmodule

// File: tb/tb_lab2_proc_mem_arb.sv
// Bench for lab2_proc_mem_arb: directed scenarios plus randomized traffic, every
// cycle compared against a queue-based model of arbitration and response routing.
`timescale 1ns/1ps
module tb_lab2_proc_mem_arb;
  import lab2_proc_mem_arb_pkg::*;

  localparam int P = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lab2_proc_mem_arb_if imem_if ();
  lab2_proc_mem_arb_if dmem_if ();
  lab2_proc_mem_arb_if mem_if ();

`ifdef LAB2_PROC_MEM_ARB_STATS_EN
  logic [31:0] num_imem_grants, num_dmem_grants, num_full_stalls;
`endif

  lab2_proc_mem_arb #(.p_max_outstanding(P)) dut (
    .clk   (clk),
    .reset (reset),
    .imem  (imem_if),
    .dmem  (dmem_if),
    .mem   (mem_if)
`ifdef LAB2_PROC_MEM_ARB_STATS_EN
    ,
    .num_imem_grants (num_imem_grants),
    .num_dmem_grants (num_dmem_grants),
    .num_full_stalls (num_full_stalls)
`endif
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic id; logic [7:0] opq; } trk_t;
  trk_t         trk_q[$];   // requests in flight, oldest first
  mem_resp_4B_t pend_q[$];  // responses the fake memory will return, in order
  int last_gnt = -1;        // -1 none since reset, 0 imem, 1 dmem
  int exp_igrants = 0, exp_dgrants = 0, exp_stalls = 0;

  // stimulus knobs (percent probabilities)
  int k_ival = 0, k_dval = 0, k_mreq_rdy = 100, k_mresp_val = 0, k_junk = 0;
  int k_irsp_rdy = 100, k_drsp_rdy = 100;
  int fix_dopq = -1;

  function automatic bit chance(input int pct);
    return $urandom_range(99, 0) < pct;
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic do_cycle();
    mem_req_4B_t  im, dm, exp_req;
    mem_resp_4B_t rsp, exp_rsp;
    logic [95:0]  r;
    bit iv, dv, full, empty, ex_mval, gi, gd, xfer, ex_mrdy, pop, mval;
    trk_t head, t;

    iv = chance(k_ival);
    dv = chance(k_dval);
    r  = {$urandom, $urandom, $urandom};
    im = mem_req_4B_t'(r[$bits(mem_req_4B_t)-1:0]);
    r  = {$urandom, $urandom, $urandom};
    dm = mem_req_4B_t'(r[$bits(mem_req_4B_t)-1:0]);
    if (fix_dopq >= 0) dm.opaque = 8'(fix_dopq);
    imem_if.reqstream_val  = iv;
    imem_if.reqstream_msg  = im;
    dmem_if.reqstream_val  = dv;
    dmem_if.reqstream_msg  = dm;
    mem_if.reqstream_rdy   = chance(k_mreq_rdy);
    imem_if.respstream_rdy = chance(k_irsp_rdy);
    dmem_if.respstream_rdy = chance(k_drsp_rdy);
    if (pend_q.size() > 0) begin
      mem_if.respstream_val = chance(k_mresp_val);
      mem_if.respstream_msg = pend_q[0];
    end else begin
      r = {$urandom, $urandom, $urandom};
      mem_if.respstream_val = chance(k_junk);
      mem_if.respstream_msg = mem_resp_4B_t'(r[$bits(mem_resp_4B_t)-1:0]);
    end
    mval = mem_if.respstream_val;

    @(negedge clk);

    // request side
    full    = (trk_q.size() == P);
    empty   = (trk_q.size() == 0);
    ex_mval = (iv || dv) && !full;
    gi      = (iv && dv) ? (last_gnt != 0) : iv;
    gd      = dv && !gi;
    xfer    = ex_mval && mem_if.reqstream_rdy;
    check_eq("mreq_val", 128'(mem_if.reqstream_val), 128'(ex_mval));
    check_eq("imem_req_rdy", 128'(imem_if.reqstream_rdy), 128'(gi && mem_if.reqstream_rdy && !full));
    check_eq("dmem_req_rdy", 128'(dmem_if.reqstream_rdy), 128'(gd && mem_if.reqstream_rdy && !full));
    if (ex_mval) begin
      exp_req        = gd ? dm : im;
      exp_req.opaque = gd ? 8'h01 : 8'h00;
      check_eq("mreq_msg", 128'(mem_if.reqstream_msg), 128'(exp_req));
    end

    // response side
    head    = empty ? trk_t'(0) : trk_q[0];
    ex_mrdy = !empty && (head.id ? dmem_if.respstream_rdy : imem_if.respstream_rdy);
    check_eq("mresp_rdy", 128'(mem_if.respstream_rdy), 128'(ex_mrdy));
    check_eq("imem_resp_val", 128'(imem_if.respstream_val), 128'(mval && !empty && !head.id));
    check_eq("dmem_resp_val", 128'(dmem_if.respstream_val), 128'(mval && !empty && head.id));
    if (mval && !empty) begin
      exp_rsp        = mem_if.respstream_msg;
      exp_rsp.opaque = head.opq;
      if (head.id) check_eq("dmem_resp_msg", 128'(dmem_if.respstream_msg), 128'(exp_rsp));
      else         check_eq("imem_resp_msg", 128'(imem_if.respstream_msg), 128'(exp_rsp));
    end

    // model update
    pop = mval && ex_mrdy;
    if (pop) begin
      void'(trk_q.pop_front());
      void'(pend_q.pop_front());
    end
    if (xfer) begin
      exp_req  = gd ? dm : im;
      t.id     = gd;
      t.opq    = exp_req.opaque;
      trk_q.push_back(t);
      rsp.msg_type = exp_req.msg_type;
      rsp.opaque   = gd ? 8'h01 : 8'h00;
      rsp.test     = 2'b00;
      rsp.len      = exp_req.len;
      rsp.data     = $urandom;
      pend_q.push_back(rsp);
      last_gnt = gd ? 1 : 0;
      if (gd) exp_dgrants++;
      else    exp_igrants++;
    end
    if ((iv || dv) && full) exp_stalls++;

    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  task automatic set_knobs(input int iv, input int dv, input int mrdy, input int mval,
                           input int junk, input int irdy, input int drdy);
    k_ival = iv; k_dval = dv; k_mreq_rdy = mrdy; k_mresp_val = mval;
    k_junk = junk; k_irsp_rdy = irdy; k_drsp_rdy = drdy;
  endtask

  // Assert reset mid-cycle with every input active; all outputs must sit at 0.
  task automatic apply_reset();
    imem_if.reqstream_val  = 1'b1;
    dmem_if.reqstream_val  = 1'b1;
    mem_if.reqstream_rdy   = 1'b1;
    mem_if.respstream_val  = 1'b1;
    imem_if.respstream_rdy = 1'b1;
    dmem_if.respstream_rdy = 1'b1;
    #2 reset = 1'b0;
    #1;
    check_eq("rst_mreq_val", 128'(mem_if.reqstream_val), 128'(0));
    check_eq("rst_imem_req_rdy", 128'(imem_if.reqstream_rdy), 128'(0));
    check_eq("rst_dmem_req_rdy", 128'(dmem_if.reqstream_rdy), 128'(0));
    check_eq("rst_mresp_rdy", 128'(mem_if.respstream_rdy), 128'(0));
    check_eq("rst_imem_resp_val", 128'(imem_if.respstream_val), 128'(0));
    check_eq("rst_dmem_resp_val", 128'(dmem_if.respstream_val), 128'(0));
    trk_q.delete();
    pend_q.delete();
    last_gnt    = -1;
    exp_igrants = 0;
    exp_dgrants = 0;
    exp_stalls  = 0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    imem_if.reqstream_val  = 1'b0;
    imem_if.reqstream_msg  = '0;
    dmem_if.reqstream_val  = 1'b0;
    dmem_if.reqstream_msg  = '0;
    mem_if.reqstream_rdy   = 1'b0;
    mem_if.respstream_val  = 1'b0;
    mem_if.respstream_msg  = '0;
    imem_if.respstream_rdy = 1'b0;
    dmem_if.respstream_rdy = 1'b0;
    @(posedge clk);
    #1;
    apply_reset();

    // Both requesters every cycle: grants alternate starting with imem, then fill.
    set_knobs(100, 100, 100, 0, 0, 100, 100);
    run(6);
    set_knobs(0, 0, 100, 100, 0, 100, 100);
    run(6);

    // dmem opaque 5A goes out as 01 and comes back restored on dmem only.
    fix_dopq = 8'h5A;
    set_knobs(0, 100, 100, 0, 0, 100, 100);
    run(1);
    fix_dopq = -1;
    set_knobs(0, 0, 100, 100, 0, 100, 100);
    run(3);

    // Responses withheld: four imem requests go, the fifth waits for a pop.
    set_knobs(100, 0, 100, 0, 0, 100, 100);
    run(6);
    set_knobs(100, 0, 100, 100, 0, 100, 100);
    run(3);
    set_knobs(0, 0, 100, 100, 0, 100, 100);
    run(6);

    // Reset with three in flight; stale response ignored; next grant is imem.
    set_knobs(100, 0, 100, 0, 0, 100, 100);
    run(3);
    apply_reset();
    set_knobs(0, 0, 100, 0, 100, 100, 100);
    run(1);
    set_knobs(100, 100, 100, 0, 0, 100, 100);
    run(2);
    set_knobs(0, 0, 100, 100, 0, 100, 100);
    run(4);

    // Randomized traffic with varying pressure on every handshake.
    for (int blk = 0; blk < 30; blk++) begin
      set_knobs($urandom_range(100, 0), $urandom_range(100, 0), $urandom_range(100, 20),
                $urandom_range(100, 10), $urandom_range(100, 0),
                $urandom_range(100, 20), $urandom_range(100, 20));
      run(100);
    end
    set_knobs(0, 0, 100, 100, 0, 100, 100);
    run(10);

`ifdef LAB2_PROC_MEM_ARB_STATS_EN
    check_eq("num_imem_grants", 128'(num_imem_grants), 128'(32'(exp_igrants)));
    check_eq("num_dmem_grants", 128'(num_dmem_grants), 128'(32'(exp_dgrants)));
    check_eq("num_full_stalls", 128'(num_full_stalls), 128'(32'(exp_stalls)));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
